// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default pixel width, FP field constants and the
// fp_max ordering rule reused by the pooling and argmax stages.
package cnn_pkg;

  localparam int          DATA_WIDTH_DEF = 32;
  localparam int          FP_SIGN_BIT    = 31;
  localparam logic [31:0] FP_POS_ZERO    = 32'h0000_0000;

  // Ties (including +0 vs -0) go to a, the earlier-arriving pixel.
  function automatic logic [31:0] fp_max(input logic [31:0] a, input logic [31:0] b);
    logic [FP_SIGN_BIT-1:0] a_mag;
    logic [FP_SIGN_BIT-1:0] b_mag;
    logic                   b_wins;
    a_mag = a[FP_SIGN_BIT-1:0];
    b_mag = b[FP_SIGN_BIT-1:0];
    if (a_mag == FP_POS_ZERO[FP_SIGN_BIT-1:0] && b_mag == FP_POS_ZERO[FP_SIGN_BIT-1:0])
      b_wins = 1'b0;
    else if (a[FP_SIGN_BIT] != b[FP_SIGN_BIT])
      b_wins = a[FP_SIGN_BIT];
    else if (!a[FP_SIGN_BIT])
      b_wins = (b_mag > a_mag);
    else
      b_wins = (b_mag < a_mag);
    return b_wins ? b : a;
  endfunction

endpackage

// File: rtl/fp_max_cmp.sv
// Combinational IEEE-754 max of two pixels; equal values (including +0 vs -0) return i_a.
// Zero latency, no flow control.
module fp_max_cmp
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_max
);

  localparam int SB = DATA_WIDTH - 1;

  logic          w_a_neg;
  logic          w_b_neg;
  logic [SB-1:0] w_a_mag;
  logic [SB-1:0] w_b_mag;
  logic          w_b_wins;

  assign w_a_neg = i_a[SB];
  assign w_b_neg = i_b[SB];
  assign w_a_mag = i_a[SB-1:0];
  assign w_b_mag = i_b[SB-1:0];

  always_comb begin
    w_b_wins = 1'b0;
    if (w_a_mag == '0 && w_b_mag == '0)
      w_b_wins = 1'b0;
    else if (w_a_neg != w_b_neg)
      w_b_wins = w_a_neg;
    else if (!w_a_neg)
      w_b_wins = (w_b_mag > w_a_mag);
    else
      w_b_wins = (w_b_mag < w_a_mag);
  end

  assign o_max = w_b_wins ? i_b : i_a;

endmodule

// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2/stride-2 max pool over a raster pixel stream; 1-cycle latency, no back-pressure.
// Define MAXPOOL_LAST_EN to add o_last marking the final pooled pixel of each frame.
module max_pool_2x2_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int IMAGE_WIDTH = 224
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
`ifdef MAXPOOL_LAST_EN
  output logic                  o_last,
`endif
  output logic [DATA_WIDTH-1:0] o_data
);

  localparam int OUT_WIDTH = IMAGE_WIDTH / 2;
  localparam int CW        = $clog2(IMAGE_WIDTH + 1);
  localparam int LB_DEPTH  = (OUT_WIDTH > 0) ? OUT_WIDTH : 1;
  localparam int LBI       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [CW-1:0] LAST_IDX  = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0] POOL_LIM  = CW'(2 * OUT_WIDTH);

  logic [CW-1:0]         r_col;
  logic [CW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_pair;
  logic                  r_o_valid;
  logic [DATA_WIDTH-1:0] r_o_data;
  logic [DATA_WIDTH-1:0] r_line_buf [LB_DEPTH];

  logic                  w_in_grid;
  logic [LBI-1:0]        w_lb_idx;
  logic [DATA_WIDTH-1:0] w_lb_rd;
  logic [DATA_WIDTH-1:0] w_h_max;
  logic [DATA_WIDTH-1:0] w_v_max;
  logic                  w_fire;

  // Trailing column/row of an odd-sized map is counted but never pooled.
  assign w_in_grid = (r_col < POOL_LIM) && (r_row < POOL_LIM);
  assign w_lb_idx  = LBI'(r_col >> 1);
  assign w_lb_rd   = r_line_buf[w_lb_idx];
  assign w_fire    = i_valid && w_in_grid && r_row[0] && r_col[0];

  fp_max_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_h_max (
    .i_a   (r_pair),
    .i_b   (i_data),
    .o_max (w_h_max)
  );

  fp_max_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_v_max (
    .i_a   (w_lb_rd),
    .i_b   (i_data),
    .o_max (w_v_max)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_valid) begin
      if (r_col == LAST_IDX) begin
        r_col <= '0;
        r_row <= (r_row == LAST_IDX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pair    <= '0;
      r_o_valid <= 1'b0;
      r_o_data  <= '0;
    end else begin
      r_o_valid <= w_fire;
      if (i_valid && w_in_grid && !r_col[0])
        r_pair <= r_row[0] ? w_v_max : i_data;
      if (w_fire)
        r_o_data <= w_h_max;
    end
  end

  // Written on even rows, read on the following odd row; contents need no reset.
  always_ff @(posedge clk) begin
    if (i_valid && w_in_grid && !r_row[0] && r_col[0])
      r_line_buf[w_lb_idx] <= w_h_max;
  end

  assign o_valid = r_o_valid;
  assign o_data  = r_o_data;

`ifdef MAXPOOL_LAST_EN
  localparam logic [CW-1:0] LAST_POOL = CW'(2 * OUT_WIDTH - 1);
  logic r_o_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_o_last <= 1'b0;
    else
      r_o_last <= w_fire && (r_row == LAST_POOL) && (r_col == LAST_POOL);
  end

  assign o_last = r_o_last;
`endif

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// Directed bench for max_pool_2x2_stream: 4x4 and 5x5 instances, expected values hand-computed.
module tb_max_pool_2x2_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid4 = 1'b0, i_valid5 = 1'b0;
  logic [31:0] i_data4 = '0, i_data5 = '0;
  logic        o_valid4, o_valid5;
  logic [31:0] o_data4, o_data5;
`ifdef MAXPOOL_LAST_EN
  logic        o_last4, o_last5;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] got4_dat[$];
  int          got4_cyc[$];
  bit          got4_last[$];
  int          exp4_cyc[$];
  logic [31:0] got5_dat[$];
  int          got5_cyc[$];
  int          exp5_cyc[$];

  max_pool_2x2_stream #(.DATA_WIDTH(32), .IMAGE_WIDTH(4)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid4),
    .i_data  (i_data4),
    .o_valid (o_valid4),
`ifdef MAXPOOL_LAST_EN
    .o_last  (o_last4),
`endif
    .o_data  (o_data4)
  );

  max_pool_2x2_stream #(.DATA_WIDTH(32), .IMAGE_WIDTH(5)) dut5 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid5),
    .i_data  (i_data5),
    .o_valid (o_valid5),
`ifdef MAXPOOL_LAST_EN
    .o_last  (o_last5),
`endif
    .o_data  (o_data5)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid4) begin
      got4_dat.push_back(o_data4);
      got4_cyc.push_back(cyc);
`ifdef MAXPOOL_LAST_EN
      got4_last.push_back(o_last4);
`else
      got4_last.push_back(1'b0);
`endif
    end
    if (o_valid5) begin
      got5_dat.push_back(o_data5);
      got5_cyc.push_back(cyc);
    end
  end

  // Positive integer n -> IEEE-754 single-precision bits.
  function automatic logic [31:0] fp_of(input int n);
    int          e;
    logic [31:0] m;
    e = 0;
    for (int k = 0; k < 24; k++) if (n >= (1 << k)) e = k;
    m = (32'(n) << (23 - e)) & 32'h007F_FFFF;
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_valid4 = 1'b0;
      i_valid5 = 1'b0;
    end
  endtask

  task automatic drive_px(input bit sel5, input logic [31:0] d, input int duty, input bit wend);
    while (int'($urandom_range(99)) >= duty) idle(1);
    @(negedge clk);
    if (sel5) begin
      i_valid4 = 1'b0;
      i_valid5 = 1'b1;
      i_data5  = d;
      if (wend) exp5_cyc.push_back(cyc + 1);
    end else begin
      i_valid5 = 1'b0;
      i_valid4 = 1'b1;
      i_data4  = d;
      if (wend) exp4_cyc.push_back(cyc + 1);
    end
  endtask

  task automatic send_frame4(input logic [31:0] px [16], input int duty);
    for (int i = 0; i < 16; i++)
      drive_px(1'b0, px[i], duty, ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1));
    idle(4);
  endtask

  task automatic send_frame5(input logic [31:0] px [25]);
    for (int i = 0; i < 25; i++)
      drive_px(1'b1, px[i], 100,
               ((i / 5) % 2 == 1) && ((i % 5) % 2 == 1) && ((i / 5) < 4) && ((i % 5) < 4));
    idle(4);
  endtask

  task automatic clear4();
    got4_dat.delete(); got4_cyc.delete(); got4_last.delete(); exp4_cyc.delete();
  endtask

  task automatic test_reset();
    idle(2);
    checks++; if (o_valid4 !== 1'b0) begin errors++; $display("FAIL reset_o_valid4 got %b want 0", o_valid4); end
    checks++; if (o_data4 !== 32'h0) begin errors++; $display("FAIL reset_o_data4 got %h want 00000000", o_data4); end
    checks++; if (o_valid5 !== 1'b0) begin errors++; $display("FAIL reset_o_valid5 got %b want 0", o_valid5); end
    checks++; if (o_data5 !== 32'h0) begin errors++; $display("FAIL reset_o_data5 got %h want 00000000", o_data5); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_frame4(input string name, input int duty);
    logic [31:0] px [16];
    logic [31:0] expv [4];
    expv = '{32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000};
    for (int i = 0; i < 16; i++) px[i] = fp_of(i + 1);
    clear4();
    send_frame4(px, duty);
    checks++;
    if (got4_dat.size() != 4) begin errors++; $display("FAIL %s_count got %0d want 4", name, got4_dat.size()); end
    for (int k = 0; k < 4; k++) begin
      if (k < got4_dat.size()) begin
        checks++;
        if (got4_dat[k] !== expv[k]) begin errors++; $display("FAIL %s_data[%0d] got %h want %h", name, k, got4_dat[k], expv[k]); end
        checks++;
        if (got4_cyc[k] != exp4_cyc[k]) begin errors++; $display("FAIL %s_cycle[%0d] got %0d want %0d", name, k, got4_cyc[k], exp4_cyc[k]); end
      end
    end
    checks++;
    if (o_valid4 !== 1'b0 || o_data4 !== 32'h4180_0000) begin
      errors++; $display("FAIL %s_hold got v=%b d=%h want v=0 d=41800000", name, o_valid4, o_data4);
    end
  endtask

  task automatic test_mixed_signs();
    logic [31:0] px [16];
    logic [31:0] expv [4];
    px = '{32'hC040_0000, 32'hBF80_0000, 32'hC0A0_0000, 32'hC000_0000,
           32'h0000_0000, 32'h8000_0000, 32'hC0E0_0000, 32'hC110_0000,
           32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
           32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
    expv = '{32'h0000_0000, 32'hC000_0000, 32'h40C0_0000, 32'h4100_0000};
    clear4();
    send_frame4(px, 100);
    checks++;
    if (got4_dat.size() != 4) begin errors++; $display("FAIL mixed_count got %0d want 4", got4_dat.size()); end
    for (int k = 0; k < 4; k++) begin
      if (k < got4_dat.size()) begin
        checks++;
        if (got4_dat[k] !== expv[k]) begin errors++; $display("FAIL mixed_data[%0d] got %h want %h", k, got4_dat[k], expv[k]); end
      end
    end
  endtask

  task automatic test_odd_width();
    logic [31:0] px [25];
    logic [31:0] expv [8];
    expv = '{32'h40E0_0000, 32'h4110_0000, 32'h4188_0000, 32'h4198_0000,
             32'h4200_0000, 32'h4208_0000, 32'h4228_0000, 32'h4230_0000};
    got5_dat.delete(); got5_cyc.delete(); exp5_cyc.delete();
    for (int i = 0; i < 25; i++) px[i] = fp_of(i + 1);
    send_frame5(px);
    for (int i = 0; i < 25; i++) px[i] = fp_of(i + 26);
    send_frame5(px);
    checks++;
    if (got5_dat.size() != 8) begin errors++; $display("FAIL w5_count got %0d want 8", got5_dat.size()); end
    for (int k = 0; k < 8; k++) begin
      if (k < got5_dat.size()) begin
        checks++;
        if (got5_dat[k] !== expv[k]) begin errors++; $display("FAIL w5_data[%0d] got %h want %h", k, got5_dat[k], expv[k]); end
        checks++;
        if (got5_cyc[k] != exp5_cyc[k]) begin errors++; $display("FAIL w5_cycle[%0d] got %0d want %0d", k, got5_cyc[k], exp5_cyc[k]); end
      end
    end
  endtask

  task automatic test_midframe_reset();
    clear4();
    for (int i = 0; i < 6; i++)
      drive_px(1'b0, fp_of(100 + i), 100, 1'b0);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    i_valid4 = 1'b0;
    #1;
    checks++; if (o_valid4 !== 1'b0) begin errors++; $display("FAIL abort_o_valid got %b want 0", o_valid4); end
    checks++; if (o_data4 !== 32'h0) begin errors++; $display("FAIL abort_o_data got %h want 00000000", o_data4); end
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    checks++;
    if (got4_dat.size() != 0) begin errors++; $display("FAIL abort_leak got %0d outputs want 0", got4_dat.size()); end
    test_frame4("after_reset", 100);
  endtask

`ifdef MAXPOOL_LAST_EN
  task automatic test_last();
    clear4();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++)
        drive_px(1'b0, fp_of(i + 1), 100, 1'b0);
    idle(4);
    checks++;
    if (got4_last.size() != 8) begin errors++; $display("FAIL last_count got %0d want 8", got4_last.size()); end
    for (int k = 0; k < 8; k++) begin
      if (k < got4_last.size()) begin
        checks++;
        if (got4_last[k] !== (k == 3 || k == 7)) begin
          errors++; $display("FAIL last_flag[%0d] got %b want %b", k, got4_last[k], (k == 3 || k == 7));
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame4("continuous", 100);
    test_frame4("duty30", 30);
    test_mixed_signs();
    test_odd_width();
    test_midframe_reset();
`ifdef MAXPOOL_LAST_EN
    test_last();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/max_pool_2x2_stream.md
Name: max_pool_2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pooling stage placed directly downstream of the 3D 3x3 convolution + ReLU stage.
- Consumes one output channel's feature map as a raster-order stream of IEEE-754 single-precision pixels, one per i_valid.
- Emits the pooled map of (IMAGE_WIDTH/2)^2 pixels in raster order.
- Uses a half-width line buffer, so no full-frame storage is needed.

Parameters:
- DATA_WIDTH, 32, pixel width (IEEE-754 single precision).
- IMAGE_WIDTH, 224, input map width and height; output width is OUT_WIDTH = IMAGE_WIDTH/2 (floor).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  i_data holds a valid pixel this cycle.
- i_data  input  DATA_WIDTH  input pixel, raster order, row-major.
- o_valid  output  1  o_data holds a pooled pixel; single-cycle pulse per output.
- o_data  output  DATA_WIDTH  pooled pixel.

Behaviour:
- Reset: o_valid=0, o_data=0, col=0, row=0, pair register cleared, line buffer contents don't-care.
- Counters: col 0..IMAGE_WIDTH-1 and row 0..IMAGE_WIDTH-1 advance only on cycles with i_valid=1. Idle gaps of any length are allowed and do not change state.
  - At col=IMAGE_WIDTH-1: col wraps to 0 and row increments.
  - At the last pixel of a frame (row=col=IMAGE_WIDTH-1): both wrap to 0, and the next i_valid starts a new frame with no dead cycle.
- fp_max(a,b) comparison:
  - Signs differ: the non-negative operand wins.
  - Both non-negative: larger magnitude wins.
  - Both negative: smaller magnitude wins.
  - Equal values, including +0 vs -0: a wins, where a is always the earlier-arriving pixel.
  - NaN inputs are unsupported; the result is the bit-level outcome of the rules above.
- Even row (row[0]=0), even col: latch the pixel into the pair register.
- Even row, odd col: write fp_max(pair, i_data) to line_buf[col>>1].
- Odd row, even col: pair <= fp_max(line_buf[col>>1], i_data).
- Odd row, odd col: result = fp_max(pair, i_data). On the next cycle: o_data=result, o_valid=1.
- Latency: exactly 1 clock from the accepting edge of the bottom-right pixel of each window to o_valid high.
- Output timing: o_valid is high for exactly one cycle per window. o_data holds its last value while o_valid=0.
- Max output rate is one pulse per 2 input pixels; no back-pressure exists.
- Odd IMAGE_WIDTH: the last column and last row are consumed for counting but never pooled (floor / "valid" pooling). With IMAGE_WIDTH=5, that is 4 outputs per 25 inputs.
- Line buffer: OUT_WIDTH entries. Each entry is written only on even rows and read only on the following odd row, so the same-address read/write hazard never occurs.
- Asynchronous reset mid-frame: aborts the frame immediately. The partial window is discarded and no o_valid is produced for it. The next accepted pixel is treated as row 0, col 0.

Optional Feature:
- Macro MAXPOOL_LAST_EN.
- Defined:
  - Adds output port o_last (1 bit, reset 0).
  - o_last is asserted together with o_valid on the final pooled pixel of each frame (output row/col = OUT_WIDTH-1) and is 0 otherwise.
  - Used by the next layer to delimit frames.
- Undefined: the port does not exist and no frame-end logic is synthesised. All other behaviour is identical.

Decomposition:
- Shared package cnn_pkg holds:
  - DATA_WIDTH default (32).
  - FP sign bit index (31).
  - Positive-zero constant.
  - The fp_max comparison rule, as a function for reuse by later pooling and argmax stages.
- One sub-module is natural: fp_max_cmp. It is combinational, with inputs a and b and output max, implementing the rule above including the tie-goes-to-a behaviour. It is instantiated twice: horizontal pair and vertical combine.

Test Plan:
- IMAGE_WIDTH=4, input pixels = 1.0..16.0 (0x3F800000..0x41800000) in raster order, continuous i_valid -> 4 o_valid pulses carrying 6.0, 8.0, 14.0, 16.0 (0x40C00000, 0x41000000, 0x41600000, 0x41800000), each 1 cycle after inputs 6, 8, 14 and 16.
- Same frame with a random i_valid duty of 30% -> identical 4 values in the same order, each exactly 1 cycle after the window's last accepted pixel.
- Mixed signs in one window: -3.0, -1.0, +0.0, -0.0 -> output 0x00000000 (+0, tie goes to the earlier operand). Window -5.0, -2.0, -7.0, -9.0 -> output -2.0 (0xC0000000).
- IMAGE_WIDTH=5, 25 pixels 1.0..25.0 -> exactly 4 outputs: 7.0, 9.0, 17.0, 19.0. The following frame starts correctly at row 0.
- Assert rst_n low after 6 pixels of a 4x4 frame, release, then send a full new frame -> no output from the aborted frame; the new frame produces the correct 4 outputs.
- With MAXPOOL_LAST_EN, two back-to-back 4x4 frames -> o_last high only on the 4th and 8th o_valid pulses.
